// File: rtl/panel_pkg.sv
// Shared constants for the front-panel blocks: button indices, clock rate,
// timing defaults and the per-button channel state encoding.
package panel_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ENTER = 4;
  localparam int BTN_ESC   = 5;

  localparam int CLK_HZ = 1_000_000;

  function automatic int ms_to_cyc(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYC_DEF = ms_to_cyc(10);
  localparam int REPEAT_DLY_DEF   = ms_to_cyc(500);
  localparam int REPEAT_PER_DEF   = ms_to_cyc(100);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_GAP    = 2'd2,
    ST_REPEAT = 2'd3
  } btn_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce counter and the
// IDLE/HELD/GAP/REPEAT state machine producing level and press strobe.
module btn_debounce_ch
  import panel_pkg::*;
#(
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DLY   = REPEAT_DLY_DEF,
  parameter int REPEAT_PER   = REPEAT_PER_DEF,
  parameter bit REPEAT_EN    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic pulse,
  output logic evt
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 1);

  logic             sync_a;
  logic             s;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rcnt;
  btn_state_t       state;

  logic settle;
  logic rise;
  logic fall;

  // The debounced edge is acted on in the same cycle stable flips, so the
  // FSM never lags the debouncer.
  assign settle = (s != stable) && (cnt == DEB_LAST);
  assign rise   = settle && s;
  assign fall   = settle && !s;
  assign evt    = rise || ((state == ST_GAP) && !fall);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      s      <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      rcnt   <= '0;
      state  <= ST_IDLE;
      lvl    <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_a <= raw;
      s      <= sync_a;
      pulse  <= evt;

      if (s == stable) begin
        cnt <= '0;
      end else if (settle) begin
        stable <= s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Release wins over every other transition, including GAP entry/exit.
      if (fall) begin
        state <= ST_IDLE;
        lvl   <= 1'b0;
        rcnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state <= ST_HELD;
              lvl   <= 1'b1;
              rcnt  <= '0;
            end
          end
          ST_HELD: begin
            if (REPEAT_EN && (rcnt == DLY_LAST)) begin
              state <= ST_GAP;
              lvl   <= 1'b0;
              rcnt  <= '0;
            end else if (rcnt != '1) begin
              rcnt <= rcnt + 1'b1;
            end
          end
          ST_GAP: begin
            state <= ST_REPEAT;
            lvl   <= 1'b1;
            rcnt  <= '0;
          end
          ST_REPEAT: begin
            if (rcnt == PER_LAST) begin
              state <= ST_GAP;
              lvl   <= 1'b0;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            lvl   <= 1'b0;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Front end for the panel push-buttons: one debounce/repeat channel per
// button plus a registered any-press strobe.
module btn_conditioner
  import panel_pkg::*;
#(
  parameter int               N_BTN        = 6,
  parameter int               CNT_W        = 20,
  parameter int               DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int               REPEAT_DLY   = REPEAT_DLY_DEF,
  parameter int               REPEAT_PER   = REPEAT_PER_DEF,
  parameter logic [N_BTN-1:0] REPEAT_MASK  = 6'b000011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_lvl,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             any_press
);

  localparam longint DEB_MAX = longint'(DEBOUNCE_CYC) - 1;
  localparam longint DLY_MAX = longint'(REPEAT_DLY) - 1;
  localparam longint PER_MAX = longint'(REPEAT_PER) - 1;

  if (((DEB_MAX >> CNT_W) != 0) || ((DLY_MAX >> CNT_W) != 0) ||
      ((PER_MAX >> CNT_W) != 0)) begin : g_cnt_w_check
    $error("btn_conditioner: CNT_W too narrow for timing parameters");
  end

  logic [N_BTN-1:0] evt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .CNT_W       (CNT_W),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_PER  (REPEAT_PER),
      .REPEAT_EN   (REPEAT_MASK[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .lvl  (btn_lvl[i]),
      .pulse(btn_pulse[i]),
      .evt  (evt[i])
    );
  end

  // Registered from the same next-cycle events, so it lines up with btn_pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |evt;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timing.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] btn_raw;
  logic [5:0] btn_lvl;
  logic [5:0] btn_pulse;
  logic       any_press;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN       (6),
    .CNT_W       (20),
    .DEBOUNCE_CYC(4),
    .REPEAT_DLY  (20),
    .REPEAT_PER  (8),
    .REPEAT_MASK (6'b000011)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_lvl  (btn_lvl),
    .btn_pulse(btn_pulse),
    .any_press(any_press)
  );

  typedef struct {
    logic       rst;
    logic [5:0] raw;
    int         adv;
    logic [5:0] lvl;
    logic [5:0] pulse;
    logic       any;
  } vec_t;

  vec_t tbl[14];

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [5:0] el,
                       input logic [5:0] ep, input logic ea);
    checks++;
    if (btn_lvl !== el || btn_pulse !== ep || any_press !== ea) begin
      errors++;
      $display("FAIL %s: got lvl=%b pulse=%b any=%b, want lvl=%b pulse=%b any=%b",
               name, btn_lvl, btn_pulse, any_press, el, ep, ea);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (btn_pulse !== 6'h00 || any_press !== 1'b0) begin
      errors++;
      $display("FAIL %s: got pulse=%b any=%b, want pulse=000000 any=0",
               name, btn_pulse, any_press);
    end
  endtask

  initial begin
    logic [5:0] el;
    logic [5:0] ep;
    logic       pat[5];
    int         j;
    int         npulse;

    // reset, clean press of enter (test cycle 10), release at 60, then 0+5 together
    tbl[0]  = '{1'b1, 6'h3f, 3,  6'h00, 6'h00, 1'b0};
    tbl[1]  = '{1'b0, 6'h00, 10, 6'h00, 6'h00, 1'b0};
    tbl[2]  = '{1'b0, 6'h10, 5,  6'h00, 6'h00, 1'b0};
    tbl[3]  = '{1'b0, 6'h10, 1,  6'h10, 6'h10, 1'b1};
    tbl[4]  = '{1'b0, 6'h10, 1,  6'h10, 6'h00, 1'b0};
    tbl[5]  = '{1'b0, 6'h10, 43, 6'h10, 6'h00, 1'b0};
    tbl[6]  = '{1'b0, 6'h00, 5,  6'h10, 6'h00, 1'b0};
    tbl[7]  = '{1'b0, 6'h00, 1,  6'h00, 6'h00, 1'b0};
    tbl[8]  = '{1'b0, 6'h00, 4,  6'h00, 6'h00, 1'b0};
    tbl[9]  = '{1'b0, 6'h21, 6,  6'h21, 6'h21, 1'b1};
    tbl[10] = '{1'b0, 6'h21, 1,  6'h21, 6'h00, 1'b0};
    tbl[11] = '{1'b0, 6'h20, 6,  6'h20, 6'h00, 1'b0};
    tbl[12] = '{1'b0, 6'h00, 6,  6'h00, 6'h00, 1'b0};
    tbl[13] = '{1'b0, 6'h00, 4,  6'h00, 6'h00, 1'b0};

    rst     = 1'b1;
    btn_raw = 6'h00;
    cyc();
    cyc();

    for (int i = 0; i < 14; i++) begin
      rst     = tbl[i].rst;
      btn_raw = tbl[i].raw;
      for (int k = 1; k < tbl[i].adv; k++) begin
        cyc();
        check_quiet($sformatf("vec%0d_gap", i));
      end
      cyc();
      check($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].pulse, tbl[i].any);
    end

    // Bounce on up: 1,0,1,0 single cycles then held; one press 6 cycles after last rise
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    npulse = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        cyc();
        check("bounce_pre", 6'h00, 6'h00, 1'b0);
      end
      btn_raw = {5'b0, pat[i]};
    end
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (btn_pulse[0]) npulse++;
      if (k < 6)       check("bounce_wait", 6'h00, 6'h00, 1'b0);
      else if (k == 6) check("bounce_rise", 6'h01, 6'h01, 1'b1);
      else             check("bounce_held", 6'h01, 6'h00, 1'b0);
    end
    checks++;
    if (npulse != 1) begin
      errors++;
      $display("FAIL bounce_count: got %0d pulses, want 1", npulse);
    end
    btn_raw = 6'h00;
    for (int k = 0; k < 10; k++) cyc();
    check("bounce_release", 6'h00, 6'h00, 1'b0);

    // Hold up for 60 cycles: gaps at T+20,29,38,47, repeats one cycle later
    btn_raw = 6'h01;
    for (int k = 1; k <= 66; k++) begin
      cyc();
      j = k - 6;
      if (k < 6) begin
        check("rep_wait", 6'h00, 6'h00, 1'b0);
      end else if (j <= 50) begin
        el = (j == 20 || j == 29 || j == 38 || j == 47) ? 6'h00 : 6'h01;
        ep = (j == 0 || j == 21 || j == 30 || j == 39 || j == 48) ? 6'h01 : 6'h00;
        check($sformatf("rep_T+%0d", j), el, ep, ep[0]);
      end else if (k == 66) begin
        check("rep_release", 6'h00, 6'h00, 1'b0);
      end
      if (k == 60) btn_raw = 6'h00;
    end
    for (int k = 0; k < 6; k++) cyc();

    // Release whose debounced fall lands on the GAP cycle
    btn_raw = 6'h01;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      j = k - 6;
      if (k < 6)        check("gapfall_wait", 6'h00, 6'h00, 1'b0);
      else if (j < 20)  check($sformatf("gapfall_T+%0d", j), 6'h01,
                              (j == 0) ? 6'h01 : 6'h00, (j == 0));
      else              check($sformatf("gapfall_T+%0d", j), 6'h00, 6'h00, 1'b0);
      if (k == 21) btn_raw = 6'h00;
    end

    // Reset with down in REPEAT and right HELD, then keep them held
    btn_raw = 6'h0a;
    for (int k = 1; k <= 28; k++) begin
      cyc();
      j = k - 6;
      if (k < 6) begin
        check("rst_seq_wait", 6'h00, 6'h00, 1'b0);
      end else begin
        el = (j == 20) ? 6'h08 : 6'h0a;
        ep = {2'b00, (j == 0), 1'b0, (j == 0 || j == 21), 1'b0};
        check($sformatf("rst_seq_T+%0d", j), el, ep, (ep != 6'h00));
      end
    end
    rst = 1'b1;
    cyc();
    check("rst_mid", 6'h00, 6'h00, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k < 6)       check("rst_after_wait", 6'h00, 6'h00, 1'b0);
      else if (k == 6) check("rst_after_press", 6'h0a, 6'h0a, 1'b1);
      else             check("rst_after_held", 6'h0a, 6'h00, 1'b0);
    end
    btn_raw = 6'h00;
    for (int k = 0; k < 8; k++) cyc();
    check("final_idle", 6'h00, 6'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
